// File: rtl/reg_dump_tx_pkg.sv
// Shared definitions for the register-dump UART transmitter: FSM state codes,
// 8N1 framing constants and the record byte selector.
package reg_dump_tx_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEL     = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_CAPT    = 3'd3;
  localparam logic [2:0] ST_START_B = 3'd4;
  localparam logic [2:0] ST_DATA_B  = 3'd5;
  localparam logic [2:0] ST_STOP_B  = 3'd6;
  localparam logic [2:0] ST_FIN     = 3'd7;

  localparam logic START_BIT    = 1'b0;
  localparam logic STOP_BIT     = 1'b1;
  localparam int   DATA_BITS    = 8;
  localparam int   RECORD_BYTES = 5;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_START = 2'd1,
    PH_DATA  = 2'd2,
    PH_STOP  = 2'd3
  } phase_t;

  // Byte n of a record: index first, then the captured word MSB first.
  function automatic logic [7:0] record_byte(input logic [4:0] idx,
                                             input logic [31:0] word,
                                             input logic [2:0] n);
    logic [7:0] b;
    case (n)
      3'd0:    b = {3'b000, idx};
      3'd1:    b = word[31:24];
      3'd2:    b = word[23:16];
      3'd3:    b = word[15:8];
      3'd4:    b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/reg_dump_tx_uart_tx_byte.sv
// 8N1 byte serializer with load/ready handshake; ready rises in the last cycle
// of the stop bit so the next byte can follow without an idle bit.
module uart_tx_byte
  import reg_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       bit_end,
  output logic       last_data,
  output logic       tx
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

  phase_t      phase_r;
  logic [15:0] baud_cnt_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  shreg_r;
  logic        tx_r;
  logic        bit_end_s;
  logic        ready_s;

  assign bit_end_s = (phase_r != PH_IDLE) && (baud_cnt_r == BAUD_LAST);
  assign ready_s   = (phase_r == PH_IDLE) || ((phase_r == PH_STOP) && bit_end_s);

  // Bit sequencing: baud counter, bit counter, shift register and line flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r    <= PH_IDLE;
      baud_cnt_r <= 16'd0;
      bit_cnt_r  <= 3'd0;
      shreg_r    <= 8'h00;
      tx_r       <= STOP_BIT;
    end else if (load && ready_s) begin
      phase_r    <= PH_START;
      baud_cnt_r <= 16'd0;
      bit_cnt_r  <= 3'd0;
      shreg_r    <= data;
      tx_r       <= START_BIT;
    end else if (bit_end_s) begin
      baud_cnt_r <= 16'd0;
      case (phase_r)
        PH_START: begin
          phase_r   <= PH_DATA;
          bit_cnt_r <= 3'd0;
          tx_r      <= shreg_r[0];
          shreg_r   <= {1'b0, shreg_r[7:1]};
        end
        PH_DATA: begin
          if (bit_cnt_r == BIT_LAST) begin
            phase_r <= PH_STOP;
            tx_r    <= STOP_BIT;
          end else begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            tx_r      <= shreg_r[0];
            shreg_r   <= {1'b0, shreg_r[7:1]};
          end
        end
        default: begin
          phase_r <= PH_IDLE;
          tx_r    <= STOP_BIT;
        end
      endcase
    end else if (phase_r != PH_IDLE) begin
      baud_cnt_r <= baud_cnt_r + 16'd1;
    end
  end

  assign ready     = ready_s;
  assign bit_end   = bit_end_s;
  assign last_data = (bit_cnt_r == BIT_LAST);
  assign tx        = tx_r;

endmodule

// File: rtl/reg_dump_tx.sv
// Dumps a register-file range over UART as 5-byte records (index + 32-bit word),
// handling the two-cycle register-file read latency before each record.
module reg_dump_tx
  import reg_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIRST_REG    = 0,
  parameter int LAST_REG     = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  sr,
  input  logic [31:0] rd_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);
  localparam logic [2:0] LAST_BYTE = 3'(RECORD_BYTES - 1);

  logic [2:0]  state_r;
  logic [4:0]  idx_r;
  logic [2:0]  byte_cnt_r;
  logic [31:0] shadow_r;
  logic        busy_r;
  logic        done_r;
  logic        load_req_s;
  logic        load_s;
  logic [7:0]  load_data_s;
  logic        ready_s;
  logic        bit_end_s;
  logic        last_data_s;
  logic        tx_s;

  // Byte hand-off: first byte from CAPT, later bytes in the stop bit's last cycle.
  always_comb begin
    load_req_s  = 1'b0;
    load_data_s = 8'h00;
    if (state_r == ST_CAPT) begin
      load_req_s  = 1'b1;
      load_data_s = record_byte(idx_r, shadow_r, 3'd0);
    end else if ((state_r == ST_STOP_B) && bit_end_s && (byte_cnt_r != LAST_BYTE)) begin
      load_req_s  = 1'b1;
      load_data_s = record_byte(idx_r, shadow_r, byte_cnt_r + 3'd1);
    end else begin
      load_req_s  = 1'b0;
      load_data_s = 8'h00;
    end
    load_s = load_req_s & ready_s;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .data     (load_data_s),
    .ready    (ready_s),
    .bit_end  (bit_end_s),
    .last_data(last_data_s),
    .tx       (tx_s)
  );

  // Register sequencing and record framing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= FIRST_IDX;
      byte_cnt_r <= 3'd0;
      shadow_r   <= 32'h0000_0000;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_SEL;
            idx_r   <= FIRST_IDX;
            busy_r  <= 1'b1;
          end
        end
        ST_SEL:  state_r <= ST_WAIT;
        ST_WAIT: state_r <= ST_CAPT;
        ST_CAPT: begin
          shadow_r   <= rd_data;
          byte_cnt_r <= 3'd0;
          state_r    <= ST_START_B;
        end
        ST_START_B: begin
          if (bit_end_s) state_r <= ST_DATA_B;
        end
        ST_DATA_B: begin
          if (bit_end_s && last_data_s) state_r <= ST_STOP_B;
        end
        ST_STOP_B: begin
          if (bit_end_s) begin
            if (byte_cnt_r != LAST_BYTE) begin
              byte_cnt_r <= byte_cnt_r + 3'd1;
              state_r    <= ST_START_B;
            end else if (idx_r < LAST_IDX) begin
              idx_r   <= idx_r + 5'd1;
              state_r <= ST_SEL;
            end else begin
              state_r <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          idx_r   <= FIRST_IDX;
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign sr   = idx_r;
  assign tx   = tx_s;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_reg_dump_tx.sv
// Self-checking bench for reg_dump_tx: a single-register instance and a full
// 0..31 instance, compared cycle by cycle against an idealised UART waveform.
module tb_reg_dump_tx;

  localparam int CPB   = 4;
  localparam int REC   = 3 + 50 * CPB;
  localparam int NFULL = 32;
  localparam int CAPN  = 7000;

  logic        clk = 1'b0;
  logic        rst_n_a = 1'b1, rst_n_b = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [4:0]  sr_a, sr_b;
  logic [31:0] rd_a = 32'h0, rd_b, stage_b;
  logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  logic [31:0] regs      [32];
  logic [31:0] exp_words [32];
  logic [7:0]  exp_bytes [160];
  logic        cap_tx    [CAPN];
  logic        cap_busy  [CAPN];
  logic        cap_done  [CAPN];
  logic [4:0]  cap_sr    [CAPN];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_dump_tx #(.CLKS_PER_BIT(CPB), .FIRST_REG(2), .LAST_REG(2)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .sr(sr_a), .rd_data(rd_a),
    .tx(tx_a), .busy(busy_a), .done(done_a));

  reg_dump_tx #(.CLKS_PER_BIT(CPB), .FIRST_REG(0), .LAST_REG(31)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .sr(sr_b), .rd_data(rd_b),
    .tx(tx_b), .busy(busy_b), .done(done_b));

  // Register file with a two-edge registered read path.
  always @(posedge clk) begin
    stage_b <= regs[sr_b];
    rd_b    <= stage_b;
  end

  task automatic fill_exp(input int first, input int last);
    int base;
    logic [4:0] i5;
    for (int i = first; i <= last; i++) begin
      base = (i - first) * 5;
      i5 = 5'(i);
      exp_bytes[base]     = {3'b000, i5};
      exp_bytes[base + 1] = exp_words[i][31:24];
      exp_bytes[base + 2] = exp_words[i][23:16];
      exp_bytes[base + 3] = exp_words[i][15:8];
      exp_bytes[base + 4] = exp_words[i][7:0];
    end
  endtask

  // Ideal line level k cycles after the accept edge: 3 idle cycles per record, then 50 bits.
  function automatic logic model_tx(input int k, input int nrec);
    int r, off, b, pos;
    logic [7:0] byte_v;
    if (k >= nrec * REC) return 1'b1;
    r   = k / REC;
    off = k % REC;
    if (off < 3) return 1'b1;
    b      = (off - 3) / CPB;
    pos    = b % 10;
    byte_v = exp_bytes[r * 5 + b / 10];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return byte_v[pos - 1];
  endfunction

  function automatic int dump_errs(input int n, input int nrec, input int first,
                                   output int first_bad);
    int errs = 0;
    logic bad;
    first_bad = -1;
    for (int k = 0; k < n; k++) begin
      bad = (cap_tx[k] !== model_tx(k, nrec))
         || (cap_busy[k] !== (k <= nrec * REC))
         || (cap_done[k] !== (k == nrec * REC + 1))
         || ((k < nrec * REC) && (cap_sr[k] !== 5'(first + k / REC)));
      if (bad) begin
        errs++;
        if (first_bad < 0) first_bad = k;
      end
    end
    return errs;
  endfunction

  function automatic int first_done(input int n);
    for (int k = 0; k < n; k++) if (cap_done[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int count_done(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (cap_done[k] === 1'b1) c++;
    return c;
  endfunction

  // Pulse START at the current negedge, then record n samples, one per negedge.
  task automatic capture(input bit use_b, input int n, input int restart_k,
                         input int chg_k, input logic [31:0] chg_val);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int k = 0; k < n; k++) begin
      cap_tx[k]   = use_b ? tx_b   : tx_a;
      cap_busy[k] = use_b ? busy_b : busy_a;
      cap_done[k] = use_b ? done_b : done_a;
      cap_sr[k]   = use_b ? sr_b   : sr_a;
      if (k == restart_k) begin
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      if (k == chg_k) rd_a = chg_val;
      @(negedge clk);
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 6;
    if (tx_a !== 1'b1)   begin n_fail++; $display("FAIL reset_tx_a: got %b, want 1", tx_a); end
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %b, want 0", busy_a); end
    if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done_a: got %b, want 0", done_a); end
    if (sr_a !== 5'd2)   begin n_fail++; $display("FAIL reset_sr_a: got %0d, want 2", sr_a); end
    if (tx_b !== 1'b1)   begin n_fail++; $display("FAIL reset_tx_b: got %b, want 1", tx_b); end
    if (sr_b !== 5'd0)   begin n_fail++; $display("FAIL reset_sr_b: got %0d, want 0", sr_b); end
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_record;
    int errs, bad, dk;
    logic [7:0] want [5];
    logic [7:0] got;
    want = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    rd_a = 32'hDEADBEEF;
    exp_words[2] = 32'hDEADBEEF;
    fill_exp(2, 2);
    capture(1'b0, REC + 6, -1, -1, 32'h0);
    errs = dump_errs(REC + 6, 1, 2, bad);
    n_checks++;
    if (errs !== 0) begin
      n_fail++;
      $display("FAIL single_wave: %0d bad samples, first k=%0d tx=%b want %b, want 0 bad", errs, bad, cap_tx[bad], model_tx(bad, 1));
    end
    dk = first_done(REC + 6);
    n_checks++;
    if (dk !== 204) begin n_fail++; $display("FAIL single_done_latency: got %0d, want 204", dk); end
    // Mid-bit UART decode of the five bytes against the literal record.
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 8; i++) got[i] = cap_tx[3 + (j * 10 + 1 + i) * CPB + CPB / 2];
      n_checks++;
      if (got !== want[j]) begin n_fail++; $display("FAIL single_byte%0d: got %h, want %h", j, got, want[j]); end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_capture_hold;
    int errs, bad, nd;
    logic [31:0] v1, v2;
    v1 = $urandom;
    v2 = ~v1;
    rd_a = v1;
    exp_words[2] = v1;
    fill_exp(2, 2);
    capture(1'b0, REC + 6, -1, 3, v2);
    errs = dump_errs(REC + 6, 1, 2, bad);
    n_checks++;
    if (errs !== 0) begin
      n_fail++;
      $display("FAIL capture_hold_wave: %0d bad samples, first k=%0d tx=%b want %b, want 0 bad", errs, bad, cap_tx[bad], model_tx(bad, 1));
    end
    nd = count_done(REC + 6);
    n_checks++;
    if (nd !== 1) begin n_fail++; $display("FAIL capture_hold_done_count: got %0d, want 1", nd); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_full_dump;
    int errs, bad, dk;
    for (int i = 0; i < 32; i++) begin
      regs[i] = i * 32'h01010101;
      exp_words[i] = regs[i];
    end
    fill_exp(0, 31);
    capture(1'b1, NFULL * REC + 6, -1, -1, 32'h0);
    errs = dump_errs(NFULL * REC + 6, NFULL, 0, bad);
    n_checks++;
    if (errs !== 0) begin
      n_fail++;
      $display("FAIL full_wave: %0d bad samples, first k=%0d tx=%b want %b sr=%0d, want 0 bad", errs, bad, cap_tx[bad], model_tx(bad, NFULL), cap_sr[bad]);
    end
    dk = first_done(NFULL * REC + 6);
    n_checks++;
    if (dk !== NFULL * REC + 1) begin n_fail++; $display("FAIL full_done_latency: got %0d, want %0d", dk, NFULL * REC + 1); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_restart_ignored;
    int errs, bad, nd;
    for (int i = 0; i < 32; i++) begin
      regs[i] = $urandom;
      exp_words[i] = regs[i];
    end
    fill_exp(0, 31);
    capture(1'b1, NFULL * REC + 6, 1500 + int'($urandom_range(0, 400)), -1, 32'h0);
    errs = dump_errs(NFULL * REC + 6, NFULL, 0, bad);
    n_checks++;
    if (errs !== 0) begin
      n_fail++;
      $display("FAIL restart_wave: %0d bad samples, first k=%0d tx=%b want %b, want 0 bad", errs, bad, cap_tx[bad], model_tx(bad, NFULL));
    end
    nd = count_done(NFULL * REC + 6);
    n_checks++;
    if (nd !== 1) begin n_fail++; $display("FAIL restart_done_count: got %0d, want 1", nd); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int errs, bad, nd, dk;
    int stop_k;
    for (int i = 0; i < 32; i++) begin
      regs[i] = (i == 0) ? 32'h0 : $urandom;
      exp_words[i] = regs[i];
    end
    fill_exp(0, 31);
    // Stop inside a data bit of record 0's fourth byte, where the line is low.
    stop_k = 3 + (30 + 4) * CPB + 1;
    capture(1'b1, stop_k, -1, -1, 32'h0);
    errs = dump_errs(stop_k, NFULL, 0, bad);
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL reset_mid_prefix: %0d bad samples, first k=%0d, want 0 bad", errs, bad); end
    n_checks++;
    if (tx_b !== 1'b0) begin n_fail++; $display("FAIL reset_mid_pre_tx: got %b, want 0", tx_b); end
    #2 rst_n_b = 1'b0;
    #1;
    n_checks += 3;
    if (tx_b !== 1'b1)   begin n_fail++; $display("FAIL reset_mid_tx: got %b, want 1", tx_b); end
    if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy: got %b, want 0", busy_b); end
    if (sr_b !== 5'd0)   begin n_fail++; $display("FAIL reset_mid_sr: got %0d, want 0", sr_b); end
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done_b === 1'b1) nd++;
    end
    n_checks++;
    if (nd !== 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d pulses, want 0", nd); end
    rst_n_b = 1'b1;
    capture(1'b1, NFULL * REC + 6, -1, -1, 32'h0);
    errs = dump_errs(NFULL * REC + 6, NFULL, 0, bad);
    n_checks++;
    if (errs !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_redump: %0d bad samples, first k=%0d tx=%b want %b, want 0 bad", errs, bad, cap_tx[bad], model_tx(bad, NFULL));
    end
    dk = first_done(NFULL * REC + 6);
    n_checks++;
    if (dk !== NFULL * REC + 1) begin n_fail++; $display("FAIL reset_mid_done_latency: got %0d, want %0d", dk, NFULL * REC + 1); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    test_reset();
    test_single_record();
    test_capture_hold();
    test_full_dump();
    test_restart_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
